phy_rx_unstripe: RTL and testbench

PHY_RX_UNSTRIPE -- requirements
Module: phy_rx_unstripe

---
 rtl/phy_rx_unstripe.sv | 138 +++++++++++++
 tb/tb_phy_rx_unstripe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_unstripe.sv
// Receive-side lane unstriper: locks onto four consecutive COM symbols, then
// regroups the serial byte stream into 4-lane words, dropping all-COM idle groups.
module phy_rx_unstripe #(
    parameter logic [7:0] COM   = 8'hBC,
    parameter int         LANES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       valid_out,
    output logic       active,
    output logic       error
);

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    state_t     state_r, state_s;
    logic [1:0] com_cnt_r, com_cnt_s;
    logic [1:0] lane_idx_r, lane_idx_s;
    logic [7:0] buf0_r, buf1_r, buf2_r;
    logic [7:0] out0_r, out1_r, out2_r, out3_r;
    logic       valid_out_r, active_r, error_r;
    logic       buf_we_s, load_s, drop_s;

    function automatic logic is_idle_group(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        return (b0 == COM) && (b1 == COM) && (b2 == COM) && (b3 == COM);
    endfunction

    // Next-state logic: alignment search, lane sequencing, group completion and drop detection
    always_comb begin
        state_s    = state_r;
        com_cnt_s  = com_cnt_r;
        lane_idx_s = lane_idx_r;
        buf_we_s   = 1'b0;
        load_s     = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            SEARCH: begin
                if (valid_in && (data_in == COM)) begin
                    if (com_cnt_r == 2'd3) begin
                        state_s    = ALIGNED;
                        com_cnt_s  = 2'd0;
                        lane_idx_s = 2'd0;
                    end else begin
                        com_cnt_s = com_cnt_r + 2'd1;
                    end
                end else begin
                    com_cnt_s = 2'd0;
                end
            end
            ALIGNED: begin
                if (valid_in) begin
                    buf_we_s   = 1'b1;
                    lane_idx_s = lane_idx_r + 2'd1;
                    if (lane_idx_r == LAST_LANE) begin
                        load_s = !is_idle_group(buf0_r, buf1_r, buf2_r, data_in);
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (lane_idx_r != 2'd0) begin
                    // A gap inside a group means lane alignment can no longer be trusted
                    drop_s     = 1'b1;
                    lane_idx_s = 2'd0;
                    com_cnt_s  = 2'd0;
                    state_s    = SEARCH;
                end else begin
                    lane_idx_s = lane_idx_r;
                end
            end
            default: begin
                state_s    = SEARCH;
                com_cnt_s  = 2'd0;
                lane_idx_s = 2'd0;
            end
        endcase
    end

    // State, lane buffers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= SEARCH;
            com_cnt_r   <= 2'd0;
            lane_idx_r  <= 2'd0;
            buf0_r      <= 8'h00;
            buf1_r      <= 8'h00;
            buf2_r      <= 8'h00;
            out0_r      <= 8'h00;
            out1_r      <= 8'h00;
            out2_r      <= 8'h00;
            out3_r      <= 8'h00;
            valid_out_r <= 1'b0;
            active_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            com_cnt_r   <= com_cnt_s;
            lane_idx_r  <= lane_idx_s;
            valid_out_r <= load_s;
            error_r     <= drop_s;
            active_r    <= (state_s == ALIGNED);
            if (buf_we_s) begin
                // The last lane is consumed straight from data_in, so it needs no buffer
                case (lane_idx_r)
                    2'd0:    buf0_r <= data_in;
                    2'd1:    buf1_r <= data_in;
                    2'd2:    buf2_r <= data_in;
                    default: buf2_r <= buf2_r;
                endcase
            end
            if (load_s) begin
                out0_r <= buf0_r;
                out1_r <= buf1_r;
                out2_r <= buf2_r;
                out3_r <= data_in;
            end
        end
    end

    assign out0      = out0_r;
    assign out1      = out1_r;
    assign out2      = out2_r;
    assign out3      = out3_r;
    assign valid_out = valid_out_r;
    assign active    = active_r;
    assign error     = error_r;

endmodule

// File: tb/tb_phy_rx_unstripe.sv
// Directed bench for phy_rx_unstripe: alignment, idle groups, gaps, drops and resets.
module tb_phy_rx_unstripe;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] out0, out1, out2, out3;
    logic       valid_out, active, error;

    int checks = 0;
    int errors = 0;

    phy_rx_unstripe #(.COM(8'hBC), .LANES(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .valid_out(valid_out), .active(active), .error(error)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] d, input logic v);
        @(negedge clk);
        data_in  = d;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out0, out1, out2, out3} !== 32'h0) begin
            errors++; $display("FAIL reset_outs got %h exp %h", {out0, out1, out2, out3}, 32'h0);
        end
        checks++;
        if ({valid_out, active, error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp %b", {valid_out, active, error}, 3'b000);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sync_data();
        logic [7:0] d [0:3];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(8'hBC, 1'b1);
            checks++;
            if (active !== (i == 3)) begin
                errors++; $display("FAIL sync_active[%0d] got %b exp %b", i, active, (i == 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(d[i], 1'b1);
            checks++;
            if (valid_out !== (i == 3)) begin
                errors++; $display("FAIL sync_valid[%0d] got %b exp %b", i, valid_out, (i == 3));
            end
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h11223344) begin
            errors++; $display("FAIL sync_group got %h exp %h", {out0, out1, out2, out3}, 32'h11223344);
        end
        step(8'h00, 1'b0);
        checks++;
        if ({valid_out, active, error, out0, out1, out2, out3} !== {3'b010, 32'h11223344}) begin
            errors++; $display("FAIL sync_hold got %b%b%b %h exp 010 11223344",
                               valid_out, active, error, {out0, out1, out2, out3});
        end
    endtask

    task automatic test_broken_sync();
        logic [7:0] d [0:7];
        int pulses;
        d = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        pulses = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(d[i], 1'b1);
            if (valid_out) pulses++;
            checks++;
            if (active !== (i == 7)) begin
                errors++; $display("FAIL broken_active[%0d] got %b exp %b", i, active, (i == 7));
            end
        end
        checks++;
        if (pulses !== 0 || {out0, out1, out2, out3} !== 32'h0) begin
            errors++; $display("FAIL broken_no_out got pulses %0d outs %h exp 0 00000000",
                               pulses, {out0, out1, out2, out3});
        end
    endtask

    task automatic test_idle_group();
        logic [7:0] d [0:7];
        d = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 8; i++) begin
            step(d[i], 1'b1);
            checks++;
            if (valid_out !== (i == 7) || active !== 1'b1) begin
                errors++; $display("FAIL idle_valid[%0d] got %b/%b exp %b/1", i, valid_out, active, (i == 7));
            end
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'hA1A2A3A4) begin
            errors++; $display("FAIL idle_group got %h exp %h", {out0, out1, out2, out3}, 32'hA1A2A3A4);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d [0:9];
        logic       v [0:9];
        logic       ev [0:9];
        d  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08};
        v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            step(d[i], v[i]);
            checks++;
            if ({valid_out, active, error} !== {ev[i], 1'b1, 1'b0}) begin
                errors++; $display("FAIL gaps_flags[%0d] got %b exp %b", i,
                                   {valid_out, active, error}, {ev[i], 1'b1, 1'b0});
            end
            if (i == 5) begin
                checks++;
                if ({out0, out1, out2, out3} !== 32'h01020304) begin
                    errors++; $display("FAIL gaps_first got %h exp %h", {out0, out1, out2, out3}, 32'h01020304);
                end
            end
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h05060708) begin
            errors++; $display("FAIL gaps_second got %h exp %h", {out0, out1, out2, out3}, 32'h05060708);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [0:7];
        d = '{8'h11, 8'hBC, 8'h22, 8'h33, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            step(d[i], 1'b1);
            checks++;
            if (valid_out !== (i == 3 || i == 7)) begin
                errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, valid_out, (i == 3 || i == 7));
            end
            if (i == 3) begin
                checks++;
                if ({out0, out1, out2, out3} !== 32'h11BC2233) begin
                    errors++; $display("FAIL b2b_com_data got %h exp %h", {out0, out1, out2, out3}, 32'h11BC2233);
                end
            end
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h55667788) begin
            errors++; $display("FAIL b2b_second got %h exp %h", {out0, out1, out2, out3}, 32'h55667788);
        end
    endtask

    task automatic test_mid_drop();
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        step(8'h00, 1'b0);
        checks++;
        if ({valid_out, active, error} !== 3'b001) begin
            errors++; $display("FAIL drop_flags got %b exp %b", {valid_out, active, error}, 3'b001);
        end
        checks++;
        if ({out0, out1, out2, out3} !== 32'h55667788) begin
            errors++; $display("FAIL drop_outs got %h exp %h", {out0, out1, out2, out3}, 32'h55667788);
        end
        step(8'h00, 1'b0);
        checks++;
        if ({active, error} !== 2'b00) begin
            errors++; $display("FAIL drop_pulse_width got %b exp %b", {active, error}, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            step(8'hBC, 1'b1);
            checks++;
            if (active !== (i == 3) || error !== 1'b0) begin
                errors++; $display("FAIL drop_realign[%0d] got %b/%b exp %b/0", i, active, error, (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        step(8'h01, 1'b1);
        step(8'h02, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if ({valid_out, active, error, out0, out1, out2, out3} !== 35'h0) begin
            errors++; $display("FAIL rstmid_async got %h exp %h",
                               {valid_out, active, error, out0, out1, out2, out3}, 35'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        step(8'h00, 1'b0);
        checks++;
        if ({valid_out, active, error} !== 3'b000) begin
            errors++; $display("FAIL rstmid_after got %b exp %b", {valid_out, active, error}, 3'b000);
        end
        step(8'h03, 1'b1);
        checks++;
        if ({valid_out, active, out0} !== {2'b00, 8'h00}) begin
            errors++; $display("FAIL rstmid_search got %b%b %h exp 00 00", valid_out, active, out0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        test_reset();
        test_sync_data();
        test_broken_sync();
        test_idle_group();
        test_gaps();
        test_back_to_back();
        test_mid_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
